// File: rtl/input_stager_pkg.sv
// Shared types and sizing helpers for the input_stager block and its lane buffers.
package input_stager_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } stager_state_e;

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int beats_per_word(input int d_w, input int ser_w);
        return d_w / ser_w;
    endfunction

    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stager_lane_buf.sv
// Single-lane DEPTH x D_W register buffer: one write port, one registered read port
// whose output is forced to zero whenever the read enable is low.
module stager_lane_buf
    import input_stager_pkg::*;
#(
    parameter int D_W    = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [D_W-1:0]    wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [D_W-1:0]    rdata
);

    logic [D_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero outside the read window so the array sees clean idle lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/input_stager.sv
// Serial-to-parallel operand stager for a systolic array: loads X/Y lanes serially,
// then replays them with a one-cycle-per-lane diagonal skew. Define
// INPUT_STAGER_REPLAY_EN to keep loaded operands across transfers.
module input_stager
    import input_stager_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int SER_W = 1,
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SER_W-1:0]             ser_x,
    input  logic                         ser_x_valid,
    output logic                         ser_x_ready,
    input  logic [SER_W-1:0]             ser_y,
    input  logic                         ser_y_valid,
    output logic                         ser_y_ready,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   len,
    output logic [ROWS*D_W-1:0]          out_x_flat,
    output logic [COLS*D_W-1:0]          out_y_flat,
    output logic [ROWS-1:0]              out_x_valid,
    output logic [COLS-1:0]              out_y_valid,
    output logic                         out_init,
    output logic                         busy,
    output logic                         done
);

    localparam int BEATS_PER_WORD = beats_per_word(D_W, SER_W);
    localparam int ADDR_W         = idx_w(DEPTH);
    localparam int LEN_W          = len_w(DEPTH);
    localparam int LANES          = (ROWS > COLS) ? ROWS : COLS;
    localparam int BEAT_W         = idx_w(BEATS_PER_WORD);
    localparam int XL_W           = idx_w(ROWS);
    localparam int YL_W           = idx_w(COLS);
    localparam int XFER_W         = $clog2(DEPTH + LANES + 1);
    localparam int SKEW_N         = (LANES > 1) ? LANES - 1 : 1;

    stager_state_e state, state_nxt;

    logic              start_acc;
    logic              clear_load;
    logic [LEN_W-1:0]  len_eff;
    logic [LEN_W-1:0]  xfer_len;
    logic [XFER_W-1:0] xfer_cnt;
    logic              xfer_last;
    logic [LEN_W-1:0]  rd_cnt;
    logic              rd_active;

    logic              base_en;
    logic [ADDR_W-1:0] base_addr;
    logic [SKEW_N-1:0] skew_en;
    logic [ADDR_W-1:0] skew_addr [SKEW_N];
    logic [LANES-1:0]  lane_en;
    logic [ADDR_W-1:0] lane_addr [LANES];

    logic [D_W-1:0]    shreg_x, shreg_x_nxt;
    logic [BEAT_W-1:0] beat_x;
    logic [ADDR_W-1:0] word_x;
    logic [XL_W-1:0]   lane_x;
    logic              full_x, acc_x, we_x;

    logic [D_W-1:0]    shreg_y, shreg_y_nxt;
    logic [BEAT_W-1:0] beat_y;
    logic [ADDR_W-1:0] word_y;
    logic [YL_W-1:0]   lane_y;
    logic              full_y, acc_y, we_y;

    logic [D_W-1:0]    rdata_x [ROWS];
    logic [D_W-1:0]    rdata_y [COLS];

    assign start_acc = (state == IDLE) && full_x && full_y && start;
    assign len_eff   = ((len == '0) || (len > LEN_W'(DEPTH))) ? LEN_W'(DEPTH) : len;
    assign xfer_last = (xfer_cnt == (XFER_W'(xfer_len) + XFER_W'(LANES - 2)));

`ifdef INPUT_STAGER_REPLAY_EN
    assign clear_load = 1'b0;
`else
    assign clear_load = (state == DONE);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = XFER;
            XFER:    if (xfer_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Read addresses go out one cycle ahead of presentation: word 0 is issued in the acceptance cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_len  <= '0;
            xfer_cnt  <= '0;
            rd_cnt    <= '0;
            rd_active <= 1'b0;
            out_init  <= 1'b0;
        end else begin
            out_init <= start_acc;
            if (start_acc) begin
                xfer_len  <= len_eff;
                xfer_cnt  <= '0;
                rd_cnt    <= LEN_W'(1);
                rd_active <= (len_eff > LEN_W'(1));
            end else if (state == XFER) begin
                xfer_cnt <= xfer_cnt + 1'b1;
                if (rd_active) begin
                    if (rd_cnt == (xfer_len - 1'b1)) begin
                        rd_active <= 1'b0;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign base_en   = start_acc || ((state == XFER) && rd_active);
    assign base_addr = start_acc ? '0 : rd_cnt[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            skew_en <= '0;
            for (int i = 0; i < SKEW_N; i++) begin
                skew_addr[i] <= '0;
            end
        end else begin
            skew_en[0]   <= base_en;
            skew_addr[0] <= base_addr;
            for (int i = 1; i < SKEW_N; i++) begin
                skew_en[i]   <= skew_en[i-1];
                skew_addr[i] <= skew_addr[i-1];
            end
        end
    end

    always_comb begin
        lane_en      = '0;
        lane_en[0]   = base_en;
        lane_addr[0] = base_addr;
        for (int i = 1; i < LANES; i++) begin
            lane_en[i]   = skew_en[i-1];
            lane_addr[i] = skew_addr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_x_valid <= '0;
            out_y_valid <= '0;
        end else begin
            out_x_valid <= lane_en[ROWS-1:0];
            out_y_valid <= lane_en[COLS-1:0];
        end
    end

    assign ser_x_ready = (state == IDLE) && !full_x;
    assign acc_x       = ser_x_valid && ser_x_ready;
    assign shreg_x_nxt = (shreg_x >> SER_W) | (D_W'(ser_x) << (D_W - SER_W));
    assign we_x        = acc_x && (beat_x == BEAT_W'(BEATS_PER_WORD - 1));

    // X loader: fills lane 0 addresses 0..DEPTH-1, then lane 1, and so on.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_x <= '0;
            beat_x  <= '0;
            word_x  <= '0;
            lane_x  <= '0;
            full_x  <= 1'b0;
        end else if (clear_load) begin
            beat_x <= '0;
            word_x <= '0;
            lane_x <= '0;
            full_x <= 1'b0;
        end else if (acc_x) begin
            shreg_x <= shreg_x_nxt;
            if (we_x) begin
                beat_x <= '0;
                if (word_x == ADDR_W'(DEPTH - 1)) begin
                    word_x <= '0;
                    if (lane_x == XL_W'(ROWS - 1)) begin
                        full_x <= 1'b1;
                    end else begin
                        lane_x <= lane_x + 1'b1;
                    end
                end else begin
                    word_x <= word_x + 1'b1;
                end
            end else begin
                beat_x <= beat_x + 1'b1;
            end
        end
    end

    assign ser_y_ready = (state == IDLE) && !full_y;
    assign acc_y       = ser_y_valid && ser_y_ready;
    assign shreg_y_nxt = (shreg_y >> SER_W) | (D_W'(ser_y) << (D_W - SER_W));
    assign we_y        = acc_y && (beat_y == BEAT_W'(BEATS_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_y <= '0;
            beat_y  <= '0;
            word_y  <= '0;
            lane_y  <= '0;
            full_y  <= 1'b0;
        end else if (clear_load) begin
            beat_y <= '0;
            word_y <= '0;
            lane_y <= '0;
            full_y <= 1'b0;
        end else if (acc_y) begin
            shreg_y <= shreg_y_nxt;
            if (we_y) begin
                beat_y <= '0;
                if (word_y == ADDR_W'(DEPTH - 1)) begin
                    word_y <= '0;
                    if (lane_y == YL_W'(COLS - 1)) begin
                        full_y <= 1'b1;
                    end else begin
                        lane_y <= lane_y + 1'b1;
                    end
                end else begin
                    word_y <= word_y + 1'b1;
                end
            end else begin
                beat_y <= beat_y + 1'b1;
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_x_lane
        stager_lane_buf #(
            .D_W    (D_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_buf (
            .clk   (clk),
            .rst   (rst),
            .we    (we_x && (lane_x == XL_W'(r))),
            .waddr (word_x),
            .wdata (shreg_x_nxt),
            .re    (lane_en[r]),
            .raddr (lane_addr[r]),
            .rdata (rdata_x[r])
        );
        assign out_x_flat[(r+1)*D_W-1 -: D_W] = rdata_x[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_y_lane
        stager_lane_buf #(
            .D_W    (D_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_buf (
            .clk   (clk),
            .rst   (rst),
            .we    (we_y && (lane_y == YL_W'(c))),
            .waddr (word_y),
            .wdata (shreg_y_nxt),
            .re    (lane_en[c]),
            .raddr (lane_addr[c]),
            .rdata (rdata_y[c])
        );
        assign out_y_flat[(c+1)*D_W-1 -: D_W] = rdata_y[c];
    end

endmodule

// File: tb/tb_input_stager.sv
// Randomised scoreboard bench for input_stager: a word-level model predicts every
// transfer cycle, and a monitor compares whatever the DUT presents against it.
module tb_input_stager;

    localparam int D_W   = 8;
    localparam int SER_W = 2;
    localparam int ROWS  = 2;
    localparam int COLS  = 3;
    localparam int DEPTH = 4;
    localparam int LEN_W = 3;
    localparam int NL    = 3;
    localparam int BPW   = D_W / SER_W;
    localparam int XN    = ROWS * DEPTH;
    localparam int YN    = COLS * DEPTH;

    logic                clk = 1'b0;
    logic                rst;
    logic [SER_W-1:0]    ser_x, ser_y;
    logic                ser_x_valid, ser_y_valid;
    logic                ser_x_ready, ser_y_ready;
    logic                start;
    logic [LEN_W-1:0]    len;
    logic [ROWS*D_W-1:0] out_x_flat;
    logic [COLS*D_W-1:0] out_y_flat;
    logic [ROWS-1:0]     out_x_valid;
    logic [COLS-1:0]     out_y_valid;
    logic                out_init, busy, done;

    input_stager #(
        .D_W(D_W), .SER_W(SER_W), .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .ser_x(ser_x), .ser_x_valid(ser_x_valid), .ser_x_ready(ser_x_ready),
        .ser_y(ser_y), .ser_y_valid(ser_y_valid), .ser_y_ready(ser_y_ready),
        .start(start), .len(len),
        .out_x_flat(out_x_flat), .out_y_flat(out_y_flat),
        .out_x_valid(out_x_valid), .out_y_valid(out_y_valid),
        .out_init(out_init), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROWS*D_W-1:0] xf;
        logic [COLS*D_W-1:0] yf;
        logic [ROWS-1:0]     xv;
        logic [COLS-1:0]     yv;
        logic                init;
        logic                dn;
    } obs_t;

    obs_t           exp_q [$];
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [D_W-1:0] x_seq [XN];
    logic [D_W-1:0] y_seq [YN];
    int             x_loaded = 0;
    int             y_loaded = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected per-cycle picture of a transfer of l words, from acceptance+1 through the done cycle.
    task automatic push_transfer(input int l);
        for (int j = 1; j <= l + NL; j++) begin
            obs_t e;
            e      = '0;
            e.init = (j == 1);
            e.dn   = (j == l + NL);
            for (int r = 0; r < ROWS; r++) begin
                int k = j - 1 - r;
                if (k >= 0 && k < l) begin
                    e.xv[r] = 1'b1;
                    e.xf[r*D_W +: D_W] = x_seq[r*DEPTH + k];
                end
            end
            for (int c = 0; c < COLS; c++) begin
                int k = j - 1 - c;
                if (k >= 0 && k < l) begin
                    e.yv[c] = 1'b1;
                    e.yf[c*D_W +: D_W] = y_seq[c*DEPTH + k];
                end
            end
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (busy || out_init || done || (|out_x_valid) || (|out_y_valid)) begin
            obs_t o;
            o = {out_x_flat, out_y_flat, out_x_valid, out_y_valid, out_init, done};
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", 64'(o), 64'd0);
            end else begin
                checkOutput("xfer_cycle", 64'(o), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_x_word(input logic [D_W-1:0] w, input bit gaps);
        for (int b = 0; b < BPW; b++) begin
            int  n = 0;
            bit  acc = 1'b0;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    ser_x_valid = 1'b0;
                    ser_x       = SER_W'($urandom);
                    @(posedge clk); #1;
                end
            end
            ser_x       = w[b*SER_W +: SER_W];
            ser_x_valid = 1'b1;
            while (!acc && n < 100) begin
                @(negedge clk); acc = ser_x_ready;
                @(posedge clk); #1; n++;
            end
            if (!acc) checkOutput("x_beat_timeout", 64'd0, 64'd1);
            ser_x_valid = 1'b0;
            ser_x       = SER_W'($urandom);
            if (gaps) begin
                @(posedge clk); #1;
            end
        end
        x_loaded++;
    endtask

    task automatic send_y_word(input logic [D_W-1:0] w);
        for (int b = 0; b < BPW; b++) begin
            int  n = 0;
            bit  acc = 1'b0;
            ser_y       = w[b*SER_W +: SER_W];
            ser_y_valid = 1'b1;
            while (!acc && n < 100) begin
                @(negedge clk); acc = ser_y_ready;
                @(posedge clk); #1; n++;
            end
            if (!acc) checkOutput("y_beat_timeout", 64'd0, 64'd1);
            ser_y_valid = 1'b0;
            ser_y       = SER_W'($urandom);
        end
        y_loaded++;
    endtask

    task automatic applyStimulus(input int x_from, input int x_to, input int y_from, input int y_to, input bit x_gaps);
        fork
            for (int k = x_from; k < x_to; k++) send_x_word(x_seq[k], x_gaps);
            for (int k = y_from; k < y_to; k++) send_y_word(y_seq[k]);
        join
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        x_loaded = 0;
        y_loaded = 0;
    endtask

    task automatic randomize_words();
        for (int k = 0; k < XN; k++) x_seq[k] = D_W'($urandom);
        for (int k = 0; k < YN; k++) y_seq[k] = D_W'($urandom);
    endtask

    task automatic run_transfer(input logic [LEN_W-1:0] l_in);
        bit acc;
        int l;
        acc = (x_loaded == XN) && (y_loaded == YN);
        l   = (l_in == 0 || int'(l_in) > DEPTH) ? DEPTH : int'(l_in);
        start = 1'b1;
        len   = l_in;
        if (acc) push_transfer(l);
        @(posedge clk); #1;
        start = 1'b0;
        len   = LEN_W'($urandom);
        if (acc) begin
            @(negedge clk);
            checkOutput("busy_after_start", 64'(busy), 64'd1);
            checkOutput("x_ready_in_xfer", 64'(ser_x_ready), 64'd0);
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (l + NL - 1) @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("busy_after_done", 64'(busy), 64'd0);
`ifndef INPUT_STAGER_REPLAY_EN
            x_loaded = 0;
            y_loaded = 0;
`endif
            checkOutput("x_ready_after_done", 64'(ser_x_ready), 64'(x_loaded < XN));
            checkOutput("y_ready_after_done", 64'(ser_y_ready), 64'(y_loaded < YN));
            @(posedge clk); #1;
        end else begin
            repeat (3) begin
                @(negedge clk);
                checkOutput("ignored_start_busy", 64'(busy), 64'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0;
        ser_x = '0; ser_y = '0; ser_x_valid = 1'b0; ser_y_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_init", 64'(out_init), 64'd0);
        checkOutput("rst_valid", 64'({out_x_valid, out_y_valid}), 64'd0);
        checkOutput("rst_data", 64'({out_x_flat, out_y_flat}), 64'd0);
        do_reset();
        checkOutput("rst_x_ready", 64'(ser_x_ready), 64'd1);
        checkOutput("rst_y_ready", 64'(ser_y_ready), 64'd1);

        $display("[TB] scenario 1: full load, len=4");
        for (int k = 0; k < XN; k++) x_seq[k] = D_W'(8'h11 + k);
        for (int k = 0; k < YN; k++) y_seq[k] = D_W'(8'h21 + k);
        applyStimulus(0, XN, 0, YN, 1'b0);
        run_transfer(3'd4);

        $display("[TB] scenario 2: X backpressure gaps");
        do_reset();
        applyStimulus(0, XN, 0, 0, 1'b1);
        @(negedge clk);
        checkOutput("x_ready_drop", 64'(ser_x_ready), 64'd0);
        checkOutput("y_ready_indep", 64'(ser_y_ready), 64'd1);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, YN, 1'b0);
        run_transfer(3'd4);

        $display("[TB] scenario 3: early start");
        do_reset();
        randomize_words();
        applyStimulus(0, XN, 0, YN - 1, 1'b1);
        run_transfer(3'd4);
        @(negedge clk);
        checkOutput("early_x_ready", 64'(ser_x_ready), 64'd0);
        checkOutput("early_y_ready", 64'(ser_y_ready), 64'd1);
        @(posedge clk); #1;
        applyStimulus(0, 0, YN - 1, YN, 1'b0);
        run_transfer(3'd4);

        $display("[TB] scenario 4: short and out-of-range lengths");
        foreach (x_seq[k]) begin end
        for (int t = 0; t < 3; t++) begin
            logic [LEN_W-1:0] lens [3];
            lens[0] = 3'd2; lens[1] = 3'd0; lens[2] = 3'd7;
            do_reset();
            randomize_words();
            applyStimulus(0, XN, 0, YN, 1'b1);
            run_transfer(lens[t]);
        end
        do_reset();
        randomize_words();
        applyStimulus(0, XN, 0, YN, 1'b0);
        run_transfer(LEN_W'($urandom_range(1, DEPTH)));

        $display("[TB] scenario 5: reset mid-transfer");
        do_reset();
        randomize_words();
        applyStimulus(0, XN, 0, YN, 1'b1);
        start = 1'b1;
        len   = 3'd4;
        push_transfer(DEPTH);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        x_loaded = 0;
        y_loaded = 0;
        @(negedge clk);
        checkOutput("abort_outputs", 64'({out_x_flat, out_y_flat, out_x_valid, out_y_valid, out_init, busy}), 64'd0);
        checkOutput("abort_x_ready", 64'(ser_x_ready), 64'd1);
        repeat (8) begin
            @(negedge clk);
            checkOutput("abort_no_done", 64'(done), 64'd0);
        end
        @(posedge clk); #1;

        $display("[TB] scenario 6: second start after one load");
        do_reset();
        randomize_words();
        applyStimulus(0, XN, 0, YN, 1'b0);
        run_transfer(3'd4);
        run_transfer(3'd4);
        @(negedge clk);
        checkOutput("final_x_ready", 64'(ser_x_ready), 64'(x_loaded < XN));

        repeat (4) @(posedge clk);
        #1;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
